// File: rtl/pong_pkg.sv
// pong_pkg: shared state encoding, colours and default geometry for the pong pixel generators
package pong_pkg;
  typedef enum logic [1:0] {SERVE, PLAY, OVER} state_t;
  localparam logic [11:0] BALL_RGB = 12'hFFF;
  localparam logic [11:0] PAD_RGB = 12'h0F0;
  localparam logic [11:0] LINE_RGB = 12'h888;
  localparam logic [11:0] BG_RGB = 12'h000;
  localparam int DEF_H_PIX = 640;
  localparam int DEF_V_PIX = 480;
  localparam int DEF_PAD_X = 32;
  localparam int DEF_PAD_W = 4;
  localparam int DEF_PAD_H = 72;
  localparam int DEF_PAD_V = 4;
  localparam int DEF_BALL_SZ = 8;
  localparam int DEF_BALL_V = 2;
  localparam int DEF_SERVE_FRAMES = 60;
  localparam int DEF_WIN_SCORE = 9;
endpackage

// File: rtl/pong_frame_tick.sv
// pong_frame_tick: one-cycle pulse on the first cycle the scan reaches the frame-tick point
module pong_frame_tick #(
  parameter int V_PIX = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  output logic       tick
);
  logic match, prev;
  assign match = (pixel_y == 10'(V_PIX)) && (pixel_x == 10'd0);
  assign tick = match && !prev;
  // remember last cycle's match so a held coordinate yields a single tick
  always_ff @(posedge clk)
    prev <= rst ? 1'b0 : match;
endmodule

// File: rtl/pong_pixel_gen_2p.sv
// pong_pixel_gen_2p: two-player pong game state and registered pixel renderer
module pong_pixel_gen_2p
  import pong_pkg::*;
#(
  parameter int H_PIX = DEF_H_PIX,
  parameter int V_PIX = DEF_V_PIX,
  parameter int PAD_X = DEF_PAD_X,
  parameter int PAD_W = DEF_PAD_W,
  parameter int PAD_H = DEF_PAD_H,
  parameter int PAD_V = DEF_PAD_V,
  parameter int BALL_SZ = DEF_BALL_SZ,
  parameter int BALL_V = DEF_BALL_V,
  parameter int SERVE_FRAMES = DEF_SERVE_FRAMES,
  parameter int WIN_SCORE = DEF_WIN_SCORE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  btn,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        video_on,
  output logic [11:0] rgb,
  output logic [3:0]  score_l,
  output logic [3:0]  score_r,
  output logic        miss_l,
  output logic        miss_r,
  output logic        game_over
);
  localparam logic [9:0] PX = 10'(PAD_X);
  localparam logic [9:0] PW = 10'(PAD_W);
  localparam logic [9:0] PH = 10'(PAD_H);
  localparam logic [9:0] PV = 10'(PAD_V);
  localparam logic [9:0] BS = 10'(BALL_SZ);
  localparam logic [9:0] BV = 10'(BALL_V);
  localparam logic [9:0] L_FACE = 10'(PAD_X + PAD_W);
  localparam logic [9:0] R_PAD = 10'(H_PIX - PAD_X - PAD_W);
  localparam logic [9:0] PAD_MAX = 10'(V_PIX - PAD_H);
  localparam logic [9:0] PAD_C = 10'((V_PIX - PAD_H) / 2);
  localparam logic [9:0] BX_C = 10'((H_PIX - BALL_SZ) / 2);
  localparam logic [9:0] BY_C = 10'((V_PIX - BALL_SZ) / 2);
  localparam logic [9:0] BX_MAX = 10'(H_PIX - BALL_SZ);
  localparam logic [9:0] BY_MAX = 10'(V_PIX - BALL_SZ);
  localparam logic [9:0] LN = 10'(H_PIX / 2 - 1);
  localparam int SCW = $clog2(SERVE_FRAMES + 1);
  localparam logic [SCW-1:0] SC_LAST = SCW'(SERVE_FRAMES - 1);
  localparam logic [3:0] WIN = 4'(WIN_SCORE);

  function automatic logic [9:0] pad_step(input logic [9:0] y, input logic up, input logic dn);
    return (up && !dn) ? ((y < PV) ? 10'd0 : y - PV)
         : (dn && !up) ? ((y > PAD_MAX - PV) ? PAD_MAX : y + PV)
         : y;
  endfunction

  state_t state, state_n;
  logic [SCW-1:0] serve_cnt, serve_cnt_n;
  logic [9:0] pad_l, pad_l_n, pad_r, pad_r_n, ball_x, ball_x_n, ball_y, ball_y_n, by_v;
  logic dx, dx_n, dy, dy_n, dy_v;
  logic [3:0] score_l_n, score_r_n;
  logic miss_l_n, miss_r_n, tick, launch, move, ov_l, ov_r, hit_l, hit_r, out_l, out_r;
  logic in_ball, in_pad, in_line;
  logic [11:0] pix_rgb;

  pong_frame_tick #(.V_PIX(V_PIX)) u_tick (
    .clk(clk), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y), .tick(tick)
  );

  assign game_over = state == OVER;
  assign launch = state == SERVE && serve_cnt == SC_LAST;
  assign move = state == PLAY || launch;
  assign ov_l = ball_y + BS > pad_l && ball_y < pad_l + PH;
  assign ov_r = ball_y + BS > pad_r && ball_y < pad_r + PH;
  assign hit_l = !dx && ball_x >= L_FACE && ball_x < L_FACE + BV && ov_l;
  assign hit_r = dx && ball_x + BS <= R_PAD && ball_x + BS + BV > R_PAD && ov_r;
  assign out_l = !dx && !hit_l && ball_x < BV;
  assign out_r = dx && !hit_r && ball_x > BX_MAX - BV;
  assign by_v = (!dy && ball_y < BV) ? 10'd0 : (dy && ball_y > BY_MAX - BV) ? BY_MAX
              : dy ? ball_y + BV : ball_y - BV;
  assign dy_v = (!dy && ball_y < BV) ? 1'b1 : (dy && ball_y > BY_MAX - BV) ? 1'b0 : dy;

  // per-frame game update; the serve release launches the ball on that same tick
  always_comb begin
    state_n = state;
    serve_cnt_n = serve_cnt;
    pad_l_n = pad_l;
    pad_r_n = pad_r;
    ball_x_n = ball_x;
    ball_y_n = ball_y;
    dx_n = dx;
    dy_n = dy;
    score_l_n = score_l;
    score_r_n = score_r;
    miss_l_n = 1'b0;
    miss_r_n = 1'b0;
    if (tick) begin
      pad_l_n = pad_step(pad_l, btn[0], btn[1]);
      pad_r_n = pad_step(pad_r, btn[2], btn[3]);
      if (state == SERVE) begin
        serve_cnt_n = launch ? '0 : serve_cnt + 1'b1;
        state_n = launch ? PLAY : SERVE;
      end
      if (move) begin
        ball_y_n = by_v;
        dy_n = dy_v;
        ball_x_n = hit_l ? L_FACE : hit_r ? R_PAD - BS : dx ? ball_x + BV : ball_x - BV;
        dx_n = hit_l ? 1'b1 : hit_r ? 1'b0 : dx;
        if (out_l || out_r) begin
          ball_x_n = BX_C;
          ball_y_n = BY_C;
          dx_n = out_r;
          miss_l_n = out_l;
          miss_r_n = out_r;
          score_l_n = score_l + {3'b0, out_r};
          score_r_n = score_r + {3'b0, out_l};
          state_n = (score_l_n == WIN || score_r_n == WIN) ? OVER : SERVE;
        end
      end
    end
  end

  // pixel colour by priority: blanking, ball, paddles, centre line
  always_comb begin
    in_ball = state != OVER && pixel_x >= ball_x && pixel_x < ball_x + BS
              && pixel_y >= ball_y && pixel_y < ball_y + BS;
    in_pad = (pixel_x >= PX && pixel_x < L_FACE && pixel_y >= pad_l && pixel_y < pad_l + PH)
          || (pixel_x >= R_PAD && pixel_x < R_PAD + PW && pixel_y >= pad_r && pixel_y < pad_r + PH);
    in_line = pixel_x == LN || pixel_x == LN + 10'd1;
    pix_rgb = !video_on ? BG_RGB : in_ball ? BALL_RGB : in_pad ? PAD_RGB : in_line ? LINE_RGB : BG_RGB;
  end

  // state register and registered colour output
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SERVE;
      serve_cnt <= '0;
      pad_l <= PAD_C;
      pad_r <= PAD_C;
      ball_x <= BX_C;
      ball_y <= BY_C;
      dx <= 1'b1;
      dy <= 1'b1;
      score_l <= '0;
      score_r <= '0;
      miss_l <= 1'b0;
      miss_r <= 1'b0;
      rgb <= BG_RGB;
    end else begin
      state <= state_n;
      serve_cnt <= serve_cnt_n;
      pad_l <= pad_l_n;
      pad_r <= pad_r_n;
      ball_x <= ball_x_n;
      ball_y <= ball_y_n;
      dx <= dx_n;
      dy <= dy_n;
      score_l <= score_l_n;
      score_r <= score_r_n;
      miss_l <= miss_l_n;
      miss_r <= miss_r_n;
      rgb <= pix_rgb;
    end
  end
endmodule

// File: tb/tb_pong_pixel_gen_2p.sv
// tb_pong_pixel_gen_2p: randomized frame-level check of pong_pixel_gen_2p against a behavioural game model
module tb_pong_pixel_gen_2p;
  import pong_pkg::*;
  logic clk = 1'b0, rst = 1'b1, video_on = 1'b0, miss_l, miss_r, game_over;
  logic [3:0] btn = 4'd0, score_l, score_r;
  logic [9:0] pixel_x = 10'd0, pixel_y = 10'd0;
  logic [11:0] rgb;
  int n_cmp = 0, n_bad = 0;
  int m_pl, m_pr, m_bx, m_by, m_vx, m_vy, m_cnt, m_sl, m_sr;
  bit m_ml, m_mr;
  state_t m_st;

  always #5 clk = ~clk;

  pong_pixel_gen_2p dut (
    .clk(clk), .rst(rst), .btn(btn), .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
    .rgb(rgb), .score_l(score_l), .score_r(score_r), .miss_l(miss_l), .miss_r(miss_r),
    .game_over(game_over)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic model_reset();
    m_pl = 204; m_pr = 204; m_bx = 316; m_by = 236; m_vx = 2; m_vy = 2;
    m_cnt = 0; m_sl = 0; m_sr = 0; m_ml = 0; m_mr = 0; m_st = SERVE;
  endtask

  function automatic int mv(int y, bit u, bit d);
    if (u && !d) return (y - 4 < 0) ? 0 : y - 4;
    if (d && !u) return (y + 4 > 408) ? 408 : y + 4;
    return y;
  endfunction

  task automatic model_tick(input logic [3:0] b);
    int opl, opr, nx, ny;
    bit go;
    opl = m_pl; opr = m_pr; m_ml = 0; m_mr = 0;
    m_pl = mv(m_pl, b[0], b[1]);
    m_pr = mv(m_pr, b[2], b[3]);
    go = (m_st == PLAY);
    if (m_st == SERVE) begin
      m_cnt++;
      if (m_cnt == 60) begin m_cnt = 0; m_st = PLAY; go = 1; end
    end
    if (go) begin
      nx = m_bx + m_vx;
      ny = m_by + m_vy;
      if (m_vx < 0 && m_bx >= 36 && nx < 36 && m_by + 8 > opl && m_by < opl + 72) begin nx = 36; m_vx = 2; end
      else if (m_vx > 0 && m_bx + 8 <= 604 && nx + 8 > 604 && m_by + 8 > opr && m_by < opr + 72) begin nx = 596; m_vx = -2; end
      else if (nx < 0) m_ml = 1;
      else if (nx > 632) m_mr = 1;
      if (ny < 0) begin ny = 0; m_vy = 2; end
      else if (ny > 472) begin ny = 472; m_vy = -2; end
      m_bx = nx; m_by = ny;
      if (m_ml || m_mr) begin
        m_bx = 316; m_by = 236;
        m_vx = m_ml ? -2 : 2;
        if (m_ml) m_sr++; else m_sl++;
        m_st = (m_sl == 9 || m_sr == 9) ? OVER : SERVE;
      end
    end
  endtask

  function automatic int model_rgb(int px, int py, bit von);
    if (!von) return 0;
    if (m_st != OVER && px >= m_bx && px <= m_bx + 7 && py >= m_by && py <= m_by + 7) return 'hFFF;
    if (px >= 32 && px <= 35 && py >= m_pl && py < m_pl + 72) return 'h0F0;
    if (px >= 604 && px <= 607 && py >= m_pr && py < m_pr + 72) return 'h0F0;
    if (px == 319 || px == 320) return 'h888;
    return 0;
  endfunction

  task automatic check_state();
    check("pad_l", int'(dut.pad_l), m_pl);
    check("pad_r", int'(dut.pad_r), m_pr);
    check("ball_x", int'(dut.ball_x), m_bx);
    check("ball_y", int'(dut.ball_y), m_by);
    check("dx_right", int'(dut.dx), int'(m_vx > 0));
    check("dy_down", int'(dut.dy), int'(m_vy > 0));
    check("state", int'(dut.state), int'(m_st));
    check("score_l", int'(score_l), m_sl);
    check("score_r", int'(score_r), m_sr);
    check("miss_l", int'(miss_l), int'(m_ml));
    check("miss_r", int'(miss_r), int'(m_mr));
    check("game_over", int'(game_over), int'(m_st == OVER));
  endtask

  task automatic frame(input logic [3:0] b);
    int px, py;
    bit von;
    @(negedge clk);
    btn = b; pixel_x = 10'd0; pixel_y = 10'd480;
    @(negedge clk);
    model_tick(b);
    check_state();
    if ($urandom_range(0, 1) == 1) begin
      px = m_bx + int'($urandom_range(0, 8)); py = m_by + int'($urandom_range(0, 7));
    end else begin
      px = int'($urandom_range(0, 639)); py = int'($urandom_range(0, 479));
    end
    von = ($urandom_range(0, 3) != 0);
    pixel_x = 10'(px); pixel_y = 10'(py); video_on = von;
    @(negedge clk);
    check("rgb", int'(rgb), model_rgb(px, py, von));
    check("miss_l_width", int'(miss_l), 0);
    check("miss_r_width", int'(miss_r), 0);
  endtask

  function automatic logic [3:0] steer(bit rand_right);
    logic [3:0] b;
    int t;
    t = m_by - 32;
    b[1:0] = (m_pl > t + 2) ? 2'b01 : (m_pl + 2 < t) ? 2'b10 : 2'b00;
    b[3:2] = rand_right ? 2'($urandom_range(0, 3)) : (m_by + 4 < 240) ? 2'b10 : 2'b01;
    return b;
  endfunction

  task automatic pix(input int px, input int py, input bit von, input int exp, input string tag);
    @(negedge clk);
    pixel_x = 10'(px); pixel_y = 10'(py); video_on = von;
    @(negedge clk);
    check(tag, int'(rgb), exp);
  endtask

  initial begin
    int ticks, fr;
    model_reset();
    repeat (3) @(negedge clk);
    check_state();
    check("rgb_reset", int'(rgb), 0);
    rst = 1'b0;
    pix(316, 236, 1, 'hFFF, "rgb_ball_centre");
    pix(316, 236, 0, 'h000, "rgb_blank");
    pix(319, 10, 1, 'h888, "rgb_line");
    pix(33, 210, 1, 'h0F0, "rgb_pad_l");
    pix(100, 100, 1, 'h000, "rgb_bg");
    @(negedge clk);
    pixel_x = 10'd0; pixel_y = 10'd480;
    ticks = 0;
    repeat (100) begin
      #1;
      if (dut.tick) ticks++;
      @(negedge clk);
    end
    check("held_tick_once", ticks, 1);
    model_tick(4'd0);
    check_state();
    pixel_y = 10'd0;
    repeat (59) frame(4'd0);
    check("launch_state", int'(dut.state), int'(PLAY));
    check("launch_x", int'(dut.ball_x), 318);
    check("launch_y", int'(dut.ball_y), 238);
    repeat (60) frame(4'b0001);
    check("pad_l_clamp_top", int'(dut.pad_l), 0);
    repeat (5) frame(4'b0011);
    check("pad_l_both_hold", int'(dut.pad_l), 0);
    repeat (300) frame(steer(1));
    fr = 0;
    while (m_st != OVER && fr < 15000) begin
      frame(steer(0));
      fr++;
    end
    check("game_over_reached", int'(game_over), 1);
    check("score_l_win", int'(score_l), 9);
    pix(316, 236, 1, model_rgb(316, 236, 1), "rgb_over_no_ball");
    check("rgb_over_dark", int'(rgb), 0);
    repeat (3) frame(4'b0010);
    check("over_pad_moves", int'(dut.pad_l), m_pl);
    @(negedge clk);
    rst = 1'b1; pixel_x = 10'd0; pixel_y = 10'd480;
    @(negedge clk);
    model_reset();
    check_state();
    check("rgb_after_rst", int'(rgb), 0);
    rst = 1'b0; pixel_y = 10'd0;
    repeat (3) frame(4'b1000);
    check("serve_cnt_post_rst", int'(dut.serve_cnt), 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
